// File: rtl/pwm_pkg.sv
// Shared constants and dead-time state encoding for the multi-channel
// complementary PWM generator.
package pwm_pkg;

  localparam int DEF_CHANNELS = 3;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_DT_W     = 8;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic [1:0] {
    OFF_BOTH = 2'd0,
    DT_WAIT  = 2'd1,
    DRIVE_HI = 2'd2,
    DRIVE_LO = 2'd3
  } dt_state_t;

endpackage

// File: rtl/pwm_deadtime_multi_if.sv
// Configuration port of the PWM generator plus per-channel FSM state for observation.
// upd_req is a one-cycle strobe that captures period/duty/dt/center into the pending
// set; upd_ack pulses for one cycle when that pending set becomes active at a carrier
// boundary. There is no back-pressure: a new upd_req simply overwrites the pending set.
interface pwm_deadtime_multi_if #(
  parameter int CHANNELS = 3,
  parameter int CNT_W    = 16,
  parameter int DT_W     = 8
);
  logic                      upd_req;
  logic [CNT_W-1:0]          period_in;
  logic [CHANNELS*CNT_W-1:0] duty_in;
  logic [DT_W-1:0]           dt_in;
  logic                      center_in;
  logic                      upd_ack;
  logic [2*CHANNELS-1:0]     ch_state;

  modport master (
    output upd_req, period_in, duty_in, dt_in, center_in,
    input  upd_ack, ch_state
  );

  modport slave (
    input  upd_req, period_in, duty_in, dt_in, center_in,
    output upd_ack, ch_state
  );
endinterface

// File: rtl/pwm_deadtime_ch.sv
// One complementary output pair: turns the raw compare into hi/lo gate drive
// with an enforced off-time after every raw edge.
module pwm_deadtime_ch
  import pwm_pkg::*;
#(
  parameter int DT_W = DEF_DT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            raw,
  input  logic [DT_W-1:0] dt,
  output logic            hi,
  output logic            lo,
  output logic [1:0]      state_dbg
);

  dt_state_t       state;
  logic [DT_W-1:0] dtc;
  logic            target;
  logic            raw_q;
  logic            en_q;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= OFF_BOTH;
      dtc    <= '0;
      target <= 1'b0;
      raw_q  <= 1'b0;
      en_q   <= 1'b0;
      hi     <= 1'b0;
      lo     <= 1'b0;
    end else if (!enable) begin
      state <= OFF_BOTH;
      dtc   <= '0;
      raw_q <= raw;
      en_q  <= 1'b0;
      hi    <= 1'b0;
      lo    <= 1'b0;
    end else begin
      en_q  <= 1'b1;
      raw_q <= raw;
      // First enabled cycle counts as an edge so the off-time is always honoured.
      if (!en_q || (raw != raw_q)) begin
        target <= raw;
        if (dt == '0) begin
          state <= raw ? DRIVE_HI : DRIVE_LO;
          dtc   <= '0;
          hi    <= raw;
          lo    <= ~raw;
        end else begin
          state <= DT_WAIT;
          dtc   <= dt;
          hi    <= 1'b0;
          lo    <= 1'b0;
        end
      end else if (state == DT_WAIT) begin
        if (dtc <= DT_W'(1)) begin
          state <= target ? DRIVE_HI : DRIVE_LO;
          dtc   <= '0;
          hi    <= target;
          lo    <= ~target;
        end else begin
          dtc <= dtc - DT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pwm_deadtime_multi.sv
// N-channel complementary PWM: shared edge/center carrier with double-buffered
// period, duty, dead time and mode, feeding one dead-time FSM per channel.
module pwm_deadtime_multi
  import pwm_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int DT_W     = DEF_DT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  pwm_deadtime_multi_if.slave  cfg,
  output logic [CHANNELS-1:0]  pwm_hi,
  output logic [CHANNELS-1:0]  pwm_lo,
  output logic                 cycle_start
);

  logic [CNT_W-1:0]          cnt;
  logic                      dir_down;
  logic [CNT_W-1:0]          per_a, per_p;
  logic [CHANNELS*CNT_W-1:0] duty_a, duty_p;
  logic [DT_W-1:0]           dt_a, dt_p;
  logic                      center_a, center_p;
  logic                      pend;

  logic                      per_zero;
  logic                      wrap;
  logic                      boundary;
  logic                      ch_en;
  logic [CHANNELS-1:0]       raw;
  logic [2*CHANNELS-1:0]     st_dbg;

  assign per_zero = (per_a == '0);
  assign wrap     = (center_a == MODE_CENTER) ? (dir_down && (cnt == '0))
                                              : (cnt == per_a - CNT_W'(1));
  assign boundary = !enable || per_zero || wrap;
  // With no period the channels are held off rather than driving the low side.
  assign ch_en    = enable && !per_zero;

  assign cycle_start  = enable && !per_zero && (cnt == '0) && !dir_down;
  assign cfg.upd_ack  = boundary && pend;
  assign cfg.ch_state = st_dbg;

  always_comb begin
    raw = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      raw[k] = !per_zero && (cnt < duty_a[k*CNT_W +: CNT_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      dir_down <= 1'b0;
      per_a    <= '0;
      per_p    <= '0;
      duty_a   <= '0;
      duty_p   <= '0;
      dt_a     <= '0;
      dt_p     <= '0;
      center_a <= 1'b0;
      center_p <= 1'b0;
      pend     <= 1'b0;
    end else begin
      if (boundary) begin
        cnt      <= '0;
        dir_down <= 1'b0;
      end else if (center_a != MODE_CENTER) begin
        cnt <= cnt + CNT_W'(1);
      end else if (dir_down) begin
        cnt <= cnt - CNT_W'(1);
      end else if (cnt == per_a - CNT_W'(1)) begin
        dir_down <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if (boundary && pend) begin
        per_a    <= per_p;
        duty_a   <= duty_p;
        dt_a     <= dt_p;
        center_a <= center_p;
      end

      // A request landing on a boundary refills pending and waits for the next one.
      if (cfg.upd_req) begin
        per_p    <= cfg.period_in;
        duty_p   <= cfg.duty_in;
        dt_p     <= cfg.dt_in;
        center_p <= cfg.center_in;
        pend     <= 1'b1;
      end else if (boundary) begin
        pend <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    pwm_deadtime_ch #(.DT_W(DT_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .enable    (ch_en),
      .raw       (raw[k]),
      .dt        (dt_a),
      .hi        (pwm_hi[k]),
      .lo        (pwm_lo[k]),
      .state_dbg (st_dbg[2*k +: 2])
    );
  end

endmodule

// File: tb/tb_pwm_deadtime_multi.sv
// Bench for pwm_deadtime_multi: directed test-plan scenarios plus random configs,
// checked every cycle against a position-in-period / run-length reference model.
module tb_pwm_deadtime_multi;

  localparam int CH = 3;
  localparam int CW = 16;
  localparam int DW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic [CH-1:0] pwm_hi, pwm_lo;
  logic cycle_start;

  always #5 clk = ~clk;

  pwm_deadtime_multi_if #(.CHANNELS(CH), .CNT_W(CW), .DT_W(DW)) cfg_if ();

  pwm_deadtime_multi #(.CHANNELS(CH), .CNT_W(CW), .DT_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cfg         (cfg_if),
    .pwm_hi      (pwm_hi),
    .pwm_lo      (pwm_lo),
    .cycle_start (cycle_start)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // drive values applied at the next tick
  logic d_rst = 1'b0, d_en = 1'b0, d_upd = 1'b0, d_center = 1'b0;
  int   d_per = 0, d_dt = 0;
  int   d_duty[CH];

  // reference model state
  int m_per, m_dt, m_pos;
  int m_duty[CH];
  bit m_center;
  int p_per, p_dt;
  int p_duty[CH];
  bit p_center, m_pend, m_off;
  int m_run[CH];
  int m_tl[CH];
  bit m_prev[CH];
  logic [2*CH-1:0] exp_q[$];

  // observation windows for directed counts
  int w_hi[CH];
  int w_lo[CH];
  int w_cs;

  task automatic model_reset();
    m_per = 0; m_dt = 0; m_pos = 0; m_center = 0;
    p_per = 0; p_dt = 0; p_center = 0; m_pend = 0; m_off = 1;
    for (int k = 0; k < CH; k++) begin
      m_duty[k] = 0; p_duty[k] = 0; m_run[k] = 0; m_tl[k] = 0; m_prev[k] = 0;
    end
  endtask

  task automatic model_cycle();
    int len, cnt;
    bit bnd, chen;
    logic [CH-1:0] raw, nh, nl;
    logic [2*CH-1:0] e;
    len  = m_center ? 2 * m_per : m_per;
    cnt  = (m_center && m_pos >= m_per) ? (2 * m_per - 1 - m_pos) : m_pos;
    for (int k = 0; k < CH; k++) raw[k] = (m_per != 0) && (cnt < m_duty[k]);
    bnd  = !enable || (m_per == 0) || (m_pos == len - 1);
    chen = enable && (m_per != 0);

    check_eq("exp_q_size", exp_q.size(), 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check_eq("pwm_hi", pwm_hi, e[2*CH-1:CH]);
    check_eq("pwm_lo", pwm_lo, e[CH-1:0]);
    check_eq("overlap", pwm_hi & pwm_lo, 0);
    check_eq("cycle_start", cycle_start, enable && (m_per != 0) && (m_pos == 0));
    check_eq("upd_ack", cfg_if.upd_ack, bnd && m_pend);
    if (m_off) check_eq("ch_state_off", cfg_if.ch_state, 0);

    for (int k = 0; k < CH; k++) begin
      w_hi[k] += int'(pwm_hi[k]);
      w_lo[k] += int'(pwm_lo[k]);
    end
    w_cs += int'(cycle_start);

    if (!rst) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      // an output side is on once raw has held its value for more than T cycles
      for (int k = 0; k < CH; k++) begin
        if (!chen) begin
          m_run[k] = 0;
          nh[k] = 1'b0;
          nl[k] = 1'b0;
        end else begin
          if (m_run[k] == 0 || raw[k] != m_prev[k]) begin
            m_run[k] = 1;
            m_tl[k]  = m_dt;
          end else if (m_run[k] < 1000) begin
            m_run[k]++;
          end
          nh[k] = raw[k] && (m_run[k] > m_tl[k]);
          nl[k] = !raw[k] && (m_run[k] > m_tl[k]);
        end
        m_prev[k] = raw[k];
      end
      m_off = !chen;
      exp_q.push_back({nh, nl});
      m_pos = bnd ? 0 : m_pos + 1;
      if (bnd && m_pend) begin
        m_per = p_per; m_dt = p_dt; m_center = p_center; m_pend = 0;
        for (int k = 0; k < CH; k++) m_duty[k] = p_duty[k];
      end
      if (cfg_if.upd_req) begin
        p_per = d_per; p_dt = d_dt; p_center = d_center; m_pend = 1;
        for (int k = 0; k < CH; k++) p_duty[k] = d_duty[k];
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
    rst              = d_rst;
    enable           = d_en;
    cfg_if.upd_req   = d_upd;
    cfg_if.period_in = CW'(d_per);
    cfg_if.dt_in     = DW'(d_dt);
    cfg_if.center_in = d_center;
    for (int k = 0; k < CH; k++) cfg_if.duty_in[k*CW +: CW] = CW'(d_duty[k]);
    #1;
    model_cycle();
    d_upd = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic window(input int n);
    for (int k = 0; k < CH; k++) begin w_hi[k] = 0; w_lo[k] = 0; end
    w_cs = 0;
    run(n);
  endtask

  task automatic set_cfg(input int p, input int d0, input int d1, input int d2,
                         input int t, input bit c);
    d_per = p; d_duty[0] = d0; d_duty[1] = d1; d_duty[2] = d2;
    d_dt = t; d_center = c; d_upd = 1'b1;
  endtask

  task automatic wait_pos(input string tag, input int pos);
    int i;
    i = 0;
    while (m_pos != pos && i < 40) begin tick(); i++; end
    check_eq(tag, m_pos, pos);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0;
    cfg_if.upd_req = 1'b0; cfg_if.period_in = '0; cfg_if.duty_in = '0;
    cfg_if.dt_in = '0; cfg_if.center_in = 1'b0;
    for (int k = 0; k < CH; k++) d_duty[k] = 0;
    model_reset();
    exp_q.push_back('0);
    repeat (2) @(posedge clk);
    run(2);
    d_rst = 1'b1;
    run(2);

    // edge P=10, duties 3/1/0, T=2
    set_cfg(10, 3, 1, 0, 2, 1'b0);
    run(2);
    d_en = 1'b1;
    run(30);
    window(10);
    check_eq("e_hi0", w_hi[0], 1);
    check_eq("e_lo0", w_lo[0], 5);
    check_eq("e_hi1", w_hi[1], 0);
    check_eq("e_lo1", w_lo[1], 7);
    check_eq("e_lo2", w_lo[2], 10);
    check_eq("e_cs", w_cs, 1);

    // center P=8, D=3, T=1
    set_cfg(8, 3, 3, 3, 1, 1'b1);
    run(40);
    window(16);
    check_eq("c_hi0", w_hi[0], 5);
    check_eq("c_lo0", w_lo[0], 9);
    check_eq("c_cs", w_cs, 1);

    // extremes
    set_cfg(10, 12, 0, 5, 2, 1'b0);
    run(40);
    window(10);
    check_eq("x_hi0", w_hi[0], 10);
    check_eq("x_lo1", w_lo[1], 10);
    set_cfg(0, 3, 3, 3, 2, 1'b0);
    run(15);
    window(10);
    check_eq("p0_out", w_hi[0] + w_hi[1] + w_hi[2] + w_lo[0] + w_lo[1] + w_lo[2], 0);
    check_eq("p0_cs", w_cs, 0);

    // mid-period and on-boundary updates
    set_cfg(10, 3, 3, 3, 2, 1'b0);
    run(35);
    wait_pos("wait_mid", 4);
    set_cfg(10, 6, 6, 6, 2, 1'b0);
    run(25);
    window(10);
    check_eq("u_hi0", w_hi[0], 4);
    check_eq("u_lo0", w_lo[0], 2);
    wait_pos("wait_bnd", 9);
    set_cfg(10, 3, 3, 3, 2, 1'b0);
    run(25);
    window(10);
    check_eq("ub_hi0", w_hi[0], 1);

    // reset while hi is driven
    set_cfg(10, 12, 12, 12, 2, 1'b0);
    run(30);
    check_eq("pre_rst_hi", pwm_hi, 3'b111);
    d_rst = 1'b0;
    tick();
    d_rst = 1'b1;
    run(2);

    // enable drop and re-arm
    set_cfg(10, 3, 3, 3, 3, 1'b0);
    run(30);
    d_en = 1'b0;
    run(3);
    d_en = 1'b1;
    window(4);
    check_eq("en_off", w_hi[0] + w_lo[0] + w_hi[1] + w_lo[1], 0);
    run(20);

    // random configurations
    for (int r = 0; r < 40; r++) begin
      int p, len;
      p = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
      set_cfg(p, $urandom_range(0, p + 3), $urandom_range(0, p + 3),
              $urandom_range(0, p + 3), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      len = $urandom_range(20, 60);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 30) == 0) d_en = ~d_en;
        if ($urandom_range(0, 200) == 0) d_rst = 1'b0;
        tick();
        d_rst = 1'b1;
      end
      d_en = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime_multi.md
Name: pwm_deadtime_multi

Overview:
Parametrised N-channel complementary PWM generator with per-channel duty and a shared programmable period and dead time.
- Supports edge-aligned and center-aligned carriers.
- Period, duty, dead time and mode are double-buffered; new values take effect only at a carrier boundary.
- Sits between the control/config logic and the gate-driver pins. Successor to the fixed two-output PWM/dead-time top level.

Parameters:
CHANNELS, 3, number of complementary output pairs
CNT_W, 16, width of carrier counter, period and duty
DT_W, 8, width of dead-time value (clock cycles)

Ports:
clk  in  1  system clock (200 MHz nominal)
rst  in  1  synchronous, active-low reset
enable  in  1  run carrier; low = outputs forced low, counter held at 0
upd_req  in  1  one-cycle strobe: sample the four config inputs into pending registers
period_in  in  CNT_W  carrier period P in clocks
duty_in  in  CHANNELS*CNT_W  per-channel duty D; channel k = bits [k*CNT_W +: CNT_W]
dt_in  in  DT_W  dead time T in clocks
center_in  in  1  0 = edge-aligned, 1 = center-aligned
pwm_hi  out  CHANNELS  high-side gate drive
pwm_lo  out  CHANNELS  low-side gate drive
cycle_start  out  1  one-cycle pulse when the counter is at the first carrier count
upd_ack  out  1  one-cycle pulse when pending config is applied

Behaviour:
Reset (rst=0 at a clk edge):
- Counter, direction, all active and pending registers, and all dead-time counters go to 0.
- pwm_hi, pwm_lo, cycle_start and upd_ack are 0. The pending flag is clear.

Config path:
- upd_req=1 samples all config inputs into pending registers and sets the pending flag.
- At a boundary with the pending flag set: active <= pending, flag clears, upd_ack pulses in that cycle, and the counter restarts at 0 in up direction.
- A boundary is the cycle where the counter would wrap, or any cycle while enable=0 or active P=0.
- If upd_req coincides with a boundary, the new values are sampled and applied at the next boundary, not the current one.

Carrier:
- Edge mode: cnt = 0,1,…,P-1, then wraps to 0. Period is P clocks.
- Center mode: cnt = 0,…,P-1 up, then P-1,…,0 down. Period is 2P clocks.
- cycle_start pulses when cnt=0 in up direction.
- P=0: counter holds at 0 and raw drive is 0 on all channels.

Raw comparison:
- raw_k = (cnt < D_k), combinational.
- D_k=0 gives constant 0. D_k >= P gives constant 1 in both modes.
- Edge mode: raw high for D clocks per period.
- Center mode: raw high for 2D clocks, centred on the down-to-up turnaround.

Dead time, per channel (independent FSM):
- States: OFF_BOTH, DT_WAIT, DRIVE_HI, DRIVE_LO.
- Any change of raw_k forces both outputs low next cycle, loads a down-counter with T, and enters DT_WAIT with target = raw_k.
- When the counter reaches 0, the target side asserts.
- A raw change during DT_WAIT reloads T with the new target. The off-time restarts and there is no overlap.
- Rule: pwm_hi & pwm_lo is never 1.
- Latency: a raw edge at cycle N asserts the target output at N+1+T; the deasserting output falls at N+1. With T=0, outputs are registered raw with 1-cycle latency.
- A pulse with raw width <= T produces no output pulse.

Enable:
- enable=0: next cycle all outputs are 0, counter is 0, every channel is in OFF_BOTH.
- enable rising: every channel enters DT_WAIT with target = current raw_k, so a full T of off-time is enforced before the first assertion.

Reset mid-operation:
- Outputs are 0 in the cycle after the reset edge.
- No glitch high is permitted.

Decomposition:
- Package pwm_pkg holds:
  - mode constants MODE_EDGE=0 and MODE_CENTER=1;
  - dead-time FSM state encoding: OFF_BOTH, DT_WAIT, DRIVE_HI, DRIVE_LO;
  - default widths.
- Sub-module pwm_deadtime_ch handles one channel: inputs clk, rst, enable, raw and dt; outputs hi and lo. It is instantiated CHANNELS times via generate.
- The carrier counter and shadow registers stay in the top block.

Test Plan:
- Edge mode, P=10, D0=3, T=2 → pwm_hi0 high 1 clk and pwm_lo0 high 5 clks per 10-clk period; both low for 2 clks after each raw edge.
- Edge mode, P=10, D1=1, T=2 → pwm_hi1 never asserts; pwm_lo1 high 7 of 10 clks (off-time restarted).
- Center mode, P=8, D=3, T=1 → period 16, raw high 6 clks, pwm_hi 5 clks, pwm_lo 9 clks; cycle_start every 16 clks.
- Extremes with P=10: D=0 → lo high continuously after initial T; D=12 → hi continuous; P=0 → all outputs 0.
- Running P=10, D=3: upd_req with D=6 mid-period → old duty until wrap; upd_ack at boundary; next period hi high 6-T clks. Repeat with upd_req on the boundary cycle → applied one period later.
- Reset and enable: rst=0 while pwm_hi=1 → outputs 0 the next cycle. Deassert enable, then reassert → T clks of both low before the first drive. Every test checks assertion (pwm_hi & pwm_lo)==0 every cycle.
